spi_slave_core: RTL
===================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter DW, default 8, word width in bits (legal 4..32).
REQ-002 Parameter TX_IDLE, default all-ones (DW bits), word shifted out when the TX buffer is empty at word start.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 ss_n  input  1  slave select, active-low, asynchronous.
REQ-007 mosi  input  1  master out slave in, asynchronous.
REQ-008 miso  output  1  master in slave out data.
REQ-009 miso_oe  output  1  miso output enable; high while selected.
REQ-010 cpol  input  1  clock idle polarity; quasi-static.
REQ-011 cpha  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-012 lsb_first  input  1  1 = LSB shifted first, 0 = MSB first.
REQ-013 tx_data  input  DW  word to transmit.
REQ-014 tx_valid  input  1  tx_data valid.
REQ-015 tx_ready  output  1  TX holding register empty; transfer occurs when tx_valid and tx_ready are both high.
REQ-016 rx_data  output  DW  last complete received word.
REQ-017 rx_valid  output  1  one-clk pulse; rx_data updated.
REQ-018 tx_underrun  output  1  one-clk pulse; word start with empty TX buffer.
REQ-019 abort  output  1  one-clk pulse; ss_n deasserted mid-word.
REQ-020 busy  output  1  high in state XFER.

Function
REQ-021 sclk, ss_n and mosi each pass through a 2-flop synchronizer; edge detection uses the synchronized sclk and ss_n plus one delay register.
REQ-022 Operation is guaranteed for clk frequency >= 8x sclk frequency.
REQ-023 Leading edge = rising if cpol=0, falling if cpol=1; sample edge = leading if cpha=0, else trailing; shift edge = the other edge.
REQ-024 cpol, cpha and lsb_first are latched on the ss_n falling edge and held constant until ss_n rises.
REQ-025 FSM states: IDLE, XFER. IDLE->XFER on synchronized ss_n falling; XFER->IDLE on synchronized ss_n rising.
REQ-026 Word start (entering XFER, or bit counter wrap) loads the TX shift register from the holding register, which becomes empty; if the holding register is empty, TX_IDLE is loaded and tx_underrun pulses.
REQ-027 cpha=0: the first bit is presented on miso from word start; each shift edge advances miso one bit, except the shift edge that ends a word, which instead starts the next word.
REQ-028 cpha=1: the first leading (shift) edge presents the first bit; each later shift edge advances one bit.
REQ-029 On each sample edge, the synchronized mosi value enters the RX shift register (MSB-first or LSB-first per latched lsb_first), and the bit counter increments.
REQ-030 Bit counter width = clog2(DW); on the DW-th sample, rx_data <= assembled word, rx_valid pulses next clk, counter wraps to 0, and the next word starts if ss_n is still low (continuous back-to-back words).
REQ-031 tx_ready = holding register empty; a handshake and a word-start load in the same clk: the load takes the old content, and the new data is written to the holding register.
REQ-032 ss_n rising with counter != 0: abort pulses, counter cleared, no rx_valid, partial RX word discarded, rx_data unchanged; the holding register content is preserved.
REQ-033 miso_oe = synchronized ss_n low; miso = 0 when miso_oe is low.
REQ-034 Edges of sclk while in IDLE are ignored.

Reset
REQ-035 On rst: state IDLE, counters 0, shift registers 0, holding register empty, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, abort=0, busy=0, miso=0, miso_oe=0, synchronizers set to ss_n=1, sclk=cpol.
REQ-036 rst asserted mid-word takes effect on the next clk edge; the word is dropped without an abort pulse, and a new transfer requires a fresh ss_n falling edge.

Verification
REQ-037 DW=8, mode 0, MSB-first: tx_data=0xA5 preloaded; master sends 0x3C -> master receives 0xA5; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1 at word start.
REQ-038 Modes 1, 2, 3, with lsb_first=1: master sends 0x81 against tx 0x5A -> rx_data=0x81; master receives 0x5A; this holds for each mode.
REQ-039 DW=16, three back-to-back words without releasing ss_n (0x1234, 0xBEEF, 0x0001), TX refilled after each tx_ready -> three rx_valid pulses in order; no underrun.
REQ-040 Empty TX buffer at selection -> tx_underrun pulses once; master receives 0xFF (DW=8).
REQ-041 ss_n released after 5 bits -> abort pulses; no rx_valid; rx_data keeps its previous value; the next full transfer is correct.
REQ-042 rst pulsed at bit 3 of a transfer -> all outputs return to their reset values next clk; no pulses occur until a new ss_n falling edge.

Source files
------------

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave (modes 0-3, MSB/LSB first) with TX holding register and synchronized serial inputs
module spi_slave_core #(
  parameter int DW = 8,
  parameter logic [DW-1:0] TX_IDLE = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          lsb_first,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          tx_underrun,
  output logic          abort,
  output logic          busy
);
  localparam int CW = $clog2(DW);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [1:0] sclk_s, ss_s, mosi_s, vld;
  logic sclk_d, ss_d, armed, m_cpol, m_cpha, m_lsb, hold_v, miso_r;
  logic [DW-1:0] hold, tx_sr, rx_sr;
  logic [CW-1:0] cnt;
  logic ss_q, sclk_q, mosi_q, ss_fall, ss_rise, s_rise, s_fall, lead, trail;
  logic smp, shf, last, start, ws, pres, lsb_e, hs;
  logic [DW-1:0] load, src, rx_next;
  always_comb begin
    ss_q = ss_s[1];
    sclk_q = sclk_s[1];
    mosi_q = mosi_s[1];
    ss_fall = ss_d && !ss_q;
    ss_rise = !ss_d && ss_q;
    s_rise = !sclk_d && sclk_q;
    s_fall = sclk_d && !sclk_q;
    lead = m_cpol ? s_fall : s_rise;
    trail = m_cpol ? s_rise : s_fall;
    smp = state == XFER && !ss_rise && (m_cpha ? trail : lead);
    shf = state == XFER && !ss_rise && (m_cpha ? lead : trail);
    last = cnt == CW'(DW - 1);
    start = state == IDLE && ss_fall && armed;
    ws = start || (m_cpha ? smp && last : shf && cnt == '0);
    pres = shf || (start && !cpha);
    lsb_e = start ? lsb_first : m_lsb;
    hs = tx_valid && !hold_v;
    load = hold_v ? hold : TX_IDLE;
    src = ws ? load : tx_sr;
    rx_next = m_lsb ? {mosi_q, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], mosi_q};
    tx_ready = !hold_v;
    miso_oe = !ss_q;
    miso = miso_r && !ss_q;
    busy = state == XFER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= {2{cpol}};
      sclk_d <= cpol;
      ss_s <= 2'b11;
      ss_d <= 1'b1;
      mosi_s <= '0;
      vld <= '0;
      armed <= 1'b0;
      state <= IDLE;
      m_cpol <= 1'b0;
      m_cpha <= 1'b0;
      m_lsb <= 1'b0;
      hold <= '0;
      hold_v <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      cnt <= '0;
      miso_r <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      abort <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      ss_s <= {ss_s[0], ss_n};
      mosi_s <= {mosi_s[0], mosi};
      sclk_d <= sclk_q;
      ss_d <= ss_q;
      vld <= {vld[0], 1'b1};
      armed <= armed || (vld[1] && ss_q);
      rx_valid <= 1'b0;
      abort <= 1'b0;
      tx_underrun <= ws && !hold_v;
      hold_v <= hs || (hold_v && !ws);
      if (hs) hold <= tx_data;
      if (start) begin
        state <= XFER;
        m_cpol <= cpol;
        m_cpha <= cpha;
        m_lsb <= lsb_first;
        cnt <= '0;
      end
      if (state == XFER && ss_rise) begin
        state <= IDLE;
        abort <= cnt != '0;
        cnt <= '0;
      end
      if (smp) begin
        rx_sr <= rx_next;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          rx_data <= rx_next;
          rx_valid <= 1'b1;
        end
      end
      if (pres) begin
        miso_r <= lsb_e ? src[0] : src[DW-1];
        tx_sr <= lsb_e ? src >> 1 : src << 1;
      end else if (ws) begin
        tx_sr <= load;
      end
    end
  end
endmodule
